// File: rtl/mux_rr_stream.sv
// Purpose : N-channel valid/ready stream multiplexer, fixed-select or round-robin arbitration.
// Latency : one cycle from input transfer to out_valid/out_data/out_chan.
// Backpressure: single output register; in_ready drops to zero while a word is held and out_ready is low.
module mux_rr_stream #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 1,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Round-robin search start; only advances in round-robin mode.
    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    ptr_nxt;

    logic [CHANNELS-1:0] grant;
    logic                any_grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic                load_en;
    logic                take;

    // Output stage can accept a new word when empty or being drained this cycle.
    assign load_en = !out_valid | out_ready;

    // Arbitration: fixed select or first valid channel at/after ptr with wrap-around.
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        if (MODE == 0) begin
            if ((int'(sel) < CHANNELS) && in_valid[sel]) begin
                grant[sel] = 1'b1;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = SEL_W'((int'(ptr) + k) % CHANNELS);
                if (!found && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    // One-hot grant to index and AND-OR data select.
    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                grant_idx  = grant_idx | SEL_W'(i);
                grant_data = grant_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign any_grant = |grant;

    // Ready only reaches the granted channel, and never while reset is held.
    assign in_ready = grant & {CHANNELS{load_en & rst_n}};

    // An input transfer happens exactly when the output register loads.
    assign take = load_en & any_grant;

    // Next search start: one past the channel just served.
    always_comb begin
        ptr_nxt = ptr;
        if (MODE != 0 && take) begin
            if (grant_idx == SEL_W'(CHANNELS - 1)) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = grant_idx + SEL_W'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

    // Output valid: refreshed whenever the stage may load, held under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (load_en) begin
            out_valid <= any_grant;
        end
    end

    // Output payload: loads only on a transfer, otherwise keeps the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_chan <= '0;
        end else if (take) begin
            out_data <= grant_data;
            out_chan <= grant_idx;
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Purpose : directed table, corner sequences and random scoreboard run for mux_rr_stream.
// Latency : outputs checked one edge after each input vector.
// Backpressure: out_ready driven from tables and random patterns.
module tb_mux_rr_stream;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int SW = 2;

    logic            clk;
    logic            rst_n;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [SW-1:0]   sel;
    logic            out_ready;

    logic [CH-1:0]   rr_in_ready;
    logic [W-1:0]    rr_out_data;
    logic [SW-1:0]   rr_out_chan;
    logic            rr_out_valid;

    logic [CH-1:0]   fx_in_ready;
    logic [W-1:0]    fx_out_data;
    logic [SW-1:0]   fx_out_chan;
    logic            fx_out_valid;

    int checks = 0;
    int errors = 0;

    mux_rr_stream #(.WIDTH(W), .CHANNELS(CH), .MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rr_in_ready), .sel(sel), .out_data(rr_out_data),
        .out_chan(rr_out_chan), .out_valid(rr_out_valid), .out_ready(out_ready)
    );

    mux_rr_stream #(.WIDTH(W), .CHANNELS(CH), .MODE(0)) dut_fx (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(fx_in_ready), .sel(sel), .out_data(fx_out_data),
        .out_chan(fx_out_chan), .out_valid(fx_out_valid), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [CH-1:0] iv;
        logic          ordy;
        logic [CH-1:0] exp_rdy;
        logic          exp_vld;
        logic [W-1:0]  exp_data;
        logic [SW-1:0] exp_chan;
    } vec_t;

    vec_t tbl[18];

    // Random-run scoreboard state
    logic [SW+W-1:0] exp_q[$];
    logic [5:0]      cnt[CH];
    logic [SW+W-1:0] exp_word;

    initial begin
        // Round-robin table: data ch i = 0xA0+i, starting from ptr=0, output empty.
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
        tbl[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
        tbl[6]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
        tbl[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
        tbl[8]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
        tbl[9]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
        tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1};
        tbl[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1};
        tbl[12] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2};
        tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA2, 2'd2};
        tbl[15] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0};
        tbl[16] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
        tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0};

        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        sel       = 2'd0;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Reset state, with valids asserted to show ready stays low
        repeat (2) @(posedge clk);
        #3;
        chk("reset out_valid", 32'(rr_out_valid), 32'd0);
        chk("reset out_data", 32'(rr_out_data), 32'd0);
        chk("reset out_chan", 32'(rr_out_chan), 32'd0);
        chk("reset in_ready", 32'(rr_in_ready), 32'd0);
        chk("reset fx in_ready", 32'(fx_in_ready), 32'd0);
        in_valid = 4'b0000;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven round-robin vectors
        for (int i = 0; i < 18; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            #2;
            chk($sformatf("tbl%0d in_ready", i), 32'(rr_in_ready), 32'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d out_valid", i), 32'(rr_out_valid), 32'(tbl[i].exp_vld));
            chk($sformatf("tbl%0d out_data", i), 32'(rr_out_data), 32'(tbl[i].exp_data));
            chk($sformatf("tbl%0d out_chan", i), 32'(rr_out_chan), 32'(tbl[i].exp_chan));
        end

        // Backpressure with 0x5C held for three cycles, then drain and refill together
        in_data[15:8] = 8'h5C;
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("bp load data", 32'(rr_out_data), 32'h5C);
        chk("bp load chan", 32'(rr_out_chan), 32'd1);
        in_data[23:16] = 8'h77;
        in_valid = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("bp%0d in_ready", c), 32'(rr_in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d out_data", c), 32'(rr_out_data), 32'h5C);
            chk($sformatf("bp%0d out_valid", c), 32'(rr_out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #2;
        chk("bp release in_ready", 32'(rr_in_ready), 32'b0100);
        @(posedge clk);
        #1;
        chk("bp next data", 32'(rr_out_data), 32'h77);
        chk("bp next chan", 32'(rr_out_chan), 32'd2);
        chk("bp next valid", 32'(rr_out_valid), 32'd1);

        // Fixed-select instance
        in_data   = {8'hA3, 8'h3E, 8'hA1, 8'hA0};
        sel       = 2'd2;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #2;
        chk("fx sel2 in_ready", 32'(fx_in_ready), 32'b0100);
        @(posedge clk);
        #1;
        chk("fx sel2 data", 32'(fx_out_data), 32'h3E);
        chk("fx sel2 chan", 32'(fx_out_chan), 32'd2);
        chk("fx sel2 valid", 32'(fx_out_valid), 32'd1);
        sel = 2'd1;
        #2;
        chk("fx sel1 idle in_ready", 32'(fx_in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("fx sel1 idle valid", 32'(fx_out_valid), 32'd0);
        chk("fx sel1 idle data", 32'(fx_out_data), 32'h3E);
        chk("fx sel1 idle chan", 32'(fx_out_chan), 32'd2);
        sel      = 2'd3;
        in_valid = 4'b1111;
        #2;
        chk("fx sel3 in_ready", 32'(fx_in_ready), 32'b1000);
        @(posedge clk);
        #1;
        chk("fx sel3 data", 32'(fx_out_data), 32'hA3);
        chk("fx sel3 chan", 32'(fx_out_chan), 32'd3);
        out_ready = 1'b0;
        #2;
        chk("fx bp in_ready", 32'(fx_in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("fx bp hold data", 32'(fx_out_data), 32'hA3);

        // Mid-cycle reset discards the held word; round-robin restarts from ch0
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-reset valid", 32'(rr_out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset valid", 32'(rr_out_valid), 32'd0);
        chk("async reset data", 32'(rr_out_data), 32'd0);
        chk("async reset in_ready", 32'(rr_in_ready), 32'd0);
        in_valid = 4'b1000;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset in_ready", 32'(rr_in_ready), 32'b1000);
        @(posedge clk);
        #1;
        chk("post-reset chan", 32'(rr_out_chan), 32'd3);
        chk("post-reset data", 32'(rr_out_data), 32'hA3);
        in_valid = 4'b1111;
        #2;
        chk("post-reset ptr wrap", 32'(rr_in_ready), 32'b0001);
        in_valid = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Random run with per-channel sequence scoreboard, then drain
        for (int c = 0; c < CH; c++) cnt[c] = '0;
        exp_q.delete();
        for (int n = 0; n < 10010; n++) begin
            for (int c = 0; c < CH; c++) in_data[c*W +: W] = {2'(c), cnt[c]};
            if (n < 10000) begin
                in_valid  = 4'($urandom_range(0, 15));
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                in_valid  = 4'b0000;
                out_ready = 1'b1;
            end
            #3;
            if ($countones(rr_in_ready) > 1 || (rr_in_ready & ~in_valid) != 0) begin
                chk($sformatf("rand%0d in_ready", n), 32'(rr_in_ready), 32'(rr_in_ready & in_valid & -(rr_in_ready & in_valid)));
            end
            if (rr_out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("rand%0d unexpected word", n), 32'({rr_out_chan, rr_out_data}), 32'h3FF);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk($sformatf("rand%0d word", n), 32'({rr_out_chan, rr_out_data}), 32'(exp_word));
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (in_valid[c] && rr_in_ready[c]) begin
                    exp_q.push_back({2'(c), 2'(c), cnt[c]});
                    cnt[c] = cnt[c] + 6'd1;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rand drained", 32'(exp_q.size()), 32'd0);
        chk("rand out_valid idle", 32'(rr_out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
